// File: rtl/dcache_ctrl.sv
// -----------------------------------------------------------------------------
// dcache_ctrl
//
// Direct-mapped, write-back, write-allocate data cache sitting between the
// pipeline MEM stage and a slow line-wide (256-bit) data memory.
//
// Hits are served with zero added latency: load data is combinational and a
// store hit updates the selected word at the next clock edge.
//
// On a miss the pipeline is stalled while the controller works through these
// steps:
//   - Write back the dirty victim line, if there is one (WB).
//   - Read the new line (RD).
//   - Spend one settle cycle (FILL).
//   - Return to IDLE. The held access is re-evaluated there and now hits.
//
// Parameters
//   INDEX_W : index bits; the cache holds 2^INDEX_W lines of 8 words.
//   ADDR_W  : byte-address width; tag width is ADDR_W-INDEX_W-5.
//
// Ports
//   clk_i, rst_i  : clock and asynchronous active-low reset.
//   cpu_req_i     : MEM stage performs a load or store this cycle.
//   cpu_we_i      : 1 = store, 0 = load.
//   cpu_addr_i    : byte address (bits [1:0] ignored).
//   cpu_data_i    : store data.
//   cpu_data_o    : load data, valid on a hit, zero otherwise.
//   cpu_stall_o   : freezes the front of the pipeline while high.
//   mem_enable_o  : memory request valid.
//   mem_write_o   : 1 = line write-back, 0 = line read.
//   mem_addr_o    : line address (bits [4:0] zero).
//   mem_data_o    : victim line during write-back.
//   mem_data_i    : refill line, valid in the mem_ack_i cycle.
//   mem_ack_i     : one-cycle completion pulse from memory.
//   hit_cnt_o, miss_cnt_o : statistics counters, present only when the
//                   DCACHE_STATS_EN macro is defined.
// -----------------------------------------------------------------------------
module dcache_ctrl #(
    parameter int INDEX_W = 4,
    parameter int ADDR_W  = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              cpu_req_i,
    input  logic              cpu_we_i,
    input  logic [ADDR_W-1:0] cpu_addr_i,
    input  logic [31:0]       cpu_data_i,
    output logic [31:0]       cpu_data_o,
    output logic              cpu_stall_o,
    output logic              mem_enable_o,
    output logic              mem_write_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [255:0]      mem_data_o,
    input  logic [255:0]      mem_data_i,
    input  logic              mem_ack_i
`ifdef DCACHE_STATS_EN
    ,
    output logic [31:0]       hit_cnt_o,
    output logic [31:0]       miss_cnt_o
`endif
);

    localparam int TAG_W = ADDR_W - INDEX_W - 5;
    localparam int LINES = 1 << INDEX_W;

    typedef enum logic [1:0] {S_IDLE, S_WB, S_RD, S_FILL} state_e;

    state_e             state_q;
    logic [LINES-1:0]   valid_q;
    logic [LINES-1:0]   dirty_q;
    logic [TAG_W-1:0]   tag_q  [LINES];
    logic [255:0]       data_q [LINES];
    logic               mem_enable_q;
    logic               mem_write_q;

    logic [INDEX_W-1:0] idx;
    logic [TAG_W-1:0]   req_tag;
    logic [2:0]         word_sel;
    logic               hit;
    logic               miss;
    logic               store_hit;
    logic               rd_done;
    logic               unused_addr_bits;

    assign idx      = cpu_addr_i[INDEX_W+4:5];
    assign req_tag  = cpu_addr_i[ADDR_W-1:INDEX_W+5];
    assign word_sel = cpu_addr_i[4:2];
    assign unused_addr_bits = ^cpu_addr_i[1:0];

    // Hits are only recognised in IDLE. In the other states the array is
    // busy with the miss, and the held request must not be treated as a hit.
    assign hit       = cpu_req_i && (state_q == S_IDLE) && valid_q[idx]
                       && (tag_q[idx] == req_tag);
    assign miss      = cpu_req_i && (state_q == S_IDLE) && !hit;
    assign store_hit = hit && cpu_we_i;
    assign rd_done   = (state_q == S_RD) && mem_ack_i;

    assign cpu_data_o = hit ? data_q[idx][{word_sel, 5'b0} +: 32] : 32'd0;

    // Stall is forced low while reset is held. A held request would otherwise
    // look like a miss against the freshly invalidated array.
    assign cpu_stall_o = rst_i && (miss || (state_q != S_IDLE));

    assign mem_enable_o = mem_enable_q;
    assign mem_write_o  = mem_write_q;

    // WB reads the victim's tag and data straight from the arrays. The line
    // is only overwritten on the RD acknowledge, so these stay stable for the
    // whole write-back.
    always_comb begin
        mem_addr_o = '0;
        mem_data_o = '0;
        case (state_q)
            S_WB: begin
                mem_addr_o = {tag_q[idx], idx, 5'b0};
                mem_data_o = data_q[idx];
            end
            S_RD: begin
                mem_addr_o = {req_tag, idx, 5'b0};
            end
            default: begin
            end
        endcase
    end

    // Miss-handling FSM with its registered memory-port controls, plus the
    // valid/dirty bookkeeping. Reset drops the request immediately, so an
    // in-flight transaction is abandoned and never installed.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q      <= S_IDLE;
            valid_q      <= '0;
            dirty_q      <= '0;
            mem_enable_q <= 1'b0;
            mem_write_q  <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (store_hit) begin
                        dirty_q[idx] <= 1'b1;
                    end else if (miss) begin
                        mem_enable_q <= 1'b1;
                        if (valid_q[idx] && dirty_q[idx]) begin
                            state_q     <= S_WB;
                            mem_write_q <= 1'b1;
                        end else begin
                            state_q     <= S_RD;
                            mem_write_q <= 1'b0;
                        end
                    end
                end
                S_WB: begin
                    if (mem_ack_i) begin
                        state_q     <= S_RD;
                        mem_write_q <= 1'b0;
                    end
                end
                S_RD: begin
                    if (mem_ack_i) begin
                        state_q      <= S_FILL;
                        mem_enable_q <= 1'b0;
                        valid_q[idx] <= 1'b1;
                        dirty_q[idx] <= 1'b0;
                    end
                end
                S_FILL: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    // Tag and data arrays carry no reset. The valid bits alone decide whether
    // their contents mean anything.
    always_ff @(posedge clk_i) begin
        if (rd_done) begin
            data_q[idx] <= mem_data_i;
            tag_q[idx]  <= req_tag;
        end else if (store_hit) begin
            data_q[idx][{word_sel, 5'b0} +: 32] <= cpu_data_i;
        end
    end

`ifdef DCACHE_STATS_EN
    logic        from_fill_q;
    logic [31:0] hit_cnt_q;
    logic [31:0] miss_cnt_q;

    // The IDLE cycle right after FILL is the replay of an access that was
    // already counted as a miss. That cycle is excluded from the hit count.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            from_fill_q <= 1'b0;
            hit_cnt_q   <= '0;
            miss_cnt_q  <= '0;
        end else begin
            from_fill_q <= (state_q == S_FILL);
            if (hit && !from_fill_q) begin
                hit_cnt_q <= hit_cnt_q + 32'd1;
            end
            if (miss) begin
                miss_cnt_q <= miss_cnt_q + 32'd1;
            end
        end
    end

    assign hit_cnt_o  = hit_cnt_q;
    assign miss_cnt_o = miss_cnt_q;
`endif

endmodule

// File: tb/tb_dcache_ctrl.sv
// -----------------------------------------------------------------------------
// tb_dcache_ctrl
//
// Drives dcache_ctrl with directed and $urandom accesses. Every observed
// output is compared against a line/word-level reference model of the cache
// and a sparse model of backing memory.
// -----------------------------------------------------------------------------
module tb_dcache_ctrl;

    localparam int LINES = 16;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         cpu_req;
    logic         cpu_we;
    logic [31:0]  cpu_addr;
    logic [31:0]  cpu_wdata;
    logic [31:0]  cpu_rdata;
    logic         cpu_stall;
    logic         mem_en;
    logic         mem_wr;
    logic [31:0]  mem_addr;
    logic [255:0] mem_wdata;
    logic [255:0] mem_rdata;
    logic         mem_ack;
`ifdef DCACHE_STATS_EN
    logic [31:0]  hit_cnt;
    logic [31:0]  miss_cnt;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: per-line valid/dirty/tag and eight words, plus memory.
    bit           m_valid [LINES];
    bit           m_dirty [LINES];
    int unsigned  m_tag   [LINES];
    logic [31:0]  m_word  [LINES][8];
    logic [255:0] mem_model [int unsigned];
    int unsigned  exp_hits;
    int unsigned  exp_misses;

    dcache_ctrl #(.INDEX_W(4), .ADDR_W(32)) dut (
        .clk_i        (clk),
        .rst_i        (rst_n),
        .cpu_req_i    (cpu_req),
        .cpu_we_i     (cpu_we),
        .cpu_addr_i   (cpu_addr),
        .cpu_data_i   (cpu_wdata),
        .cpu_data_o   (cpu_rdata),
        .cpu_stall_o  (cpu_stall),
        .mem_enable_o (mem_en),
        .mem_write_o  (mem_wr),
        .mem_addr_o   (mem_addr),
        .mem_data_o   (mem_wdata),
        .mem_data_i   (mem_rdata),
        .mem_ack_i    (mem_ack)
`ifdef DCACHE_STATS_EN
        ,
        .hit_cnt_o    (hit_cnt),
        .miss_cnt_o   (miss_cnt)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [255:0] rand_line();
        logic [255:0] l;
        for (int k = 0; k < 8; k++) l[32*k +: 32] = $urandom;
        return l;
    endfunction

    function automatic logic [255:0] fetch_line(input int unsigned a);
        if (!mem_model.exists(a)) mem_model[a] = rand_line();
        return mem_model[a];
    endfunction

    function automatic logic [255:0] line_of(input int unsigned idx);
        logic [255:0] l;
        for (int k = 0; k < 8; k++) l[32*k +: 32] = m_word[idx][k];
        return l;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < LINES; i++) begin
            m_valid[i] = 1'b0;
            m_dirty[i] = 1'b0;
        end
        exp_hits   = 0;
        exp_misses = 0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        cpu_req = 1'b0;
        mem_ack = 1'b0;
        rst_n   = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    // One CPU access, followed cycle by cycle through any miss sequence.
    // Each cycle's outputs are checked against the model's prediction.
    task automatic run_access(input bit we, input int unsigned addr, input logic [31:0] wdata,
                              input int wb_delay, input int rd_delay);
        int unsigned  idx, tg, wd, line_addr, victim_addr;
        logic [255:0] victim, refill;
        bit           exp_hit, need_wb;
        idx       = (addr / 32) % LINES;
        tg        = addr / (32 * LINES);
        wd        = (addr % 32) / 4;
        line_addr = addr - (addr % 32);
        exp_hit   = m_valid[idx] && (m_tag[idx] == tg);
        need_wb   = !exp_hit && m_valid[idx] && m_dirty[idx];
        @(negedge clk);
        cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wdata; mem_ack = 1'b0;
        #1;
        if (exp_hit) begin
            exp_hits++;
        end else begin
            exp_misses++;
            n_checks++;
            if (cpu_stall !== 1'b1 || cpu_rdata !== 32'd0 || mem_en !== 1'b0) begin
                n_fail++;
                $display("[TB] FAIL miss_detect addr=%h: stall=%b data=%h en=%b, want stall=1 data=0 en=0",
                         addr, cpu_stall, cpu_rdata, mem_en);
            end
            if (need_wb) begin
                victim      = line_of(idx);
                victim_addr = m_tag[idx] * (32 * LINES) + idx * 32;
                for (int c = 0; c <= wb_delay; c++) begin
                    @(negedge clk);
                    mem_ack   = (c == wb_delay);
                    mem_rdata = rand_line();
                    #1;
                    n_checks++;
                    if (mem_en !== 1'b1 || mem_wr !== 1'b1 || mem_addr !== victim_addr || cpu_stall !== 1'b1) begin
                        n_fail++;
                        $display("[TB] FAIL wb_req cyc%0d: en=%b wr=%b addr=%h stall=%b, want en=1 wr=1 addr=%h stall=1",
                                 c, mem_en, mem_wr, mem_addr, cpu_stall, victim_addr);
                    end
                    n_checks++;
                    if (mem_wdata !== victim) begin
                        n_fail++;
                        $display("[TB] FAIL wb_data cyc%0d: got %h want %h", c, mem_wdata, victim);
                    end
                end
                mem_model[victim_addr] = victim;
            end
            refill = fetch_line(line_addr);
            for (int c = 0; c <= rd_delay; c++) begin
                @(negedge clk);
                mem_ack   = (c == rd_delay);
                mem_rdata = (c == rd_delay) ? refill : rand_line();
                #1;
                n_checks++;
                if (mem_en !== 1'b1 || mem_wr !== 1'b0 || mem_addr !== line_addr || cpu_stall !== 1'b1) begin
                    n_fail++;
                    $display("[TB] FAIL rd_req cyc%0d: en=%b wr=%b addr=%h stall=%b, want en=1 wr=0 addr=%h stall=1",
                             c, mem_en, mem_wr, mem_addr, cpu_stall, line_addr);
                end
            end
            // FILL cycle: the port is idle, and a stray ack here must be ignored.
            @(negedge clk);
            mem_ack   = 1'($urandom_range(0, 1));
            mem_rdata = rand_line();
            #1;
            n_checks++;
            if (mem_en !== 1'b0 || cpu_stall !== 1'b1) begin
                n_fail++;
                $display("[TB] FAIL fill: en=%b stall=%b, want en=0 stall=1", mem_en, cpu_stall);
            end
            m_valid[idx] = 1'b1;
            m_dirty[idx] = 1'b0;
            m_tag[idx]   = tg;
            for (int k = 0; k < 8; k++) m_word[idx][k] = refill[32*k +: 32];
            @(negedge clk);
            mem_ack = 1'b0;
            #1;
        end
        n_checks++;
        if (cpu_stall !== 1'b0 || mem_en !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL hit_nostall addr=%h: stall=%b en=%b, want 0 0", addr, cpu_stall, mem_en);
        end
        if (!we) begin
            n_checks++;
            if (cpu_rdata !== m_word[idx][wd]) begin
                n_fail++;
                $display("[TB] FAIL load_data addr=%h: got %h want %h", addr, cpu_rdata, m_word[idx][wd]);
            end
        end else begin
            m_word[idx][wd] = wdata;
            m_dirty[idx]    = 1'b1;
        end
        @(posedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h40;
        cpu_wdata = '0; mem_ack = 1'b0; mem_rdata = '0;
        model_reset();
        #12;
        n_checks++;
        if (cpu_stall !== 1'b0 || mem_en !== 1'b0 || mem_wr !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL reset_ctrl: stall=%b en=%b wr=%b, want 0 0 0", cpu_stall, mem_en, mem_wr);
        end
        n_checks++;
        if (mem_addr !== 32'd0 || mem_wdata !== 256'd0 || cpu_rdata !== 32'd0) begin
            n_fail++;
            $display("[TB] FAIL reset_data: addr=%h wdata=%h rdata=%h, want all 0", mem_addr, mem_wdata, cpu_rdata);
        end
`ifdef DCACHE_STATS_EN
        n_checks++;
        if (hit_cnt !== 32'd0 || miss_cnt !== 32'd0) begin
            n_fail++;
            $display("[TB] FAIL reset_cnt: hit=%0d miss=%0d, want 0 0", hit_cnt, miss_cnt);
        end
`endif
        @(negedge clk);
        cpu_req = 1'b0;
        rst_n   = 1'b1;
    endtask

    task automatic test_clean_miss();
        run_access(1'b0, 32'h40, 32'd0, 0, 0);
    endtask

    task automatic test_store_load_hit();
        run_access(1'b1, 32'h44, 32'hDEADBEEF, 0, 0);
        run_access(1'b0, 32'h44, 32'd0, 0, 0);
    endtask

    task automatic test_dirty_evict();
        run_access(1'b0, 32'h244, 32'd0, 0, 0);
    endtask

    task automatic test_delayed_ack();
        run_access(1'b0, 32'h100, 32'd0, 0, 5);
        run_access(1'b1, 32'h108, 32'h1234_5678, 0, 0);
        run_access(1'b0, 32'h300, 32'd0, 5, 5);
    endtask

    task automatic test_stray_ack();
        @(negedge clk);
        cpu_req = 1'b0;
        for (int c = 0; c < 3; c++) begin
            mem_ack   = 1'b1;
            mem_rdata = rand_line();
            #1;
            n_checks++;
            if (mem_en !== 1'b0 || cpu_stall !== 1'b0 || cpu_rdata !== 32'd0) begin
                n_fail++;
                $display("[TB] FAIL stray_ack cyc%0d: en=%b stall=%b data=%h, want 0 0 0",
                         c, mem_en, cpu_stall, cpu_rdata);
            end
            @(negedge clk);
        end
        mem_ack = 1'b0;
        run_access(1'b0, 32'h304, 32'd0, 0, 0);
    endtask

    task automatic test_reset_during_rd();
        do_reset();
        @(negedge clk);
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h40; mem_ack = 1'b0;
        @(negedge clk);
        #1;
        n_checks++;
        if (mem_en !== 1'b1 || mem_addr !== 32'h40) begin
            n_fail++;
            $display("[TB] FAIL rd_before_reset: en=%b addr=%h, want en=1 addr=00000040", mem_en, mem_addr);
        end
        mem_ack   = 1'b1;
        mem_rdata = rand_line();
        #1;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (mem_en !== 1'b0 || mem_wr !== 1'b0 || cpu_stall !== 1'b0 || mem_addr !== 32'd0) begin
            n_fail++;
            $display("[TB] FAIL async_reset: en=%b wr=%b stall=%b addr=%h, want all 0",
                     mem_en, mem_wr, cpu_stall, mem_addr);
        end
        @(posedge clk);
        #1;
        mem_ack = 1'b0;
        @(negedge clk);
        cpu_req = 1'b0;
        rst_n   = 1'b1;
        model_reset();
        run_access(1'b0, 32'h40, 32'd0, 0, 0);
    endtask

    task automatic test_random();
        int unsigned addr;
        for (int i = 0; i < 200; i++) begin
            addr = $urandom_range(0, 3) * 512 + $urandom_range(0, 15) * 32
                 + $urandom_range(0, 7) * 4 + $urandom_range(0, 3);
            if ($urandom_range(0, 4) == 0) begin
                @(negedge clk);
                cpu_req  = 1'b0;
                cpu_addr = addr;
                #1;
                n_checks++;
                if (cpu_stall !== 1'b0 || cpu_rdata !== 32'd0 || mem_en !== 1'b0) begin
                    n_fail++;
                    $display("[TB] FAIL idle_noreq: stall=%b data=%h en=%b, want 0 0 0", cpu_stall, cpu_rdata, mem_en);
                end
            end
            run_access(1'($urandom_range(0, 1)), addr, $urandom,
                       $urandom_range(0, 3), $urandom_range(0, 3));
        end
`ifdef DCACHE_STATS_EN
        #1;
        n_checks++;
        if (hit_cnt !== exp_hits || miss_cnt !== exp_misses) begin
            n_fail++;
            $display("[TB] FAIL random_counts: hit=%0d miss=%0d, want %0d %0d", hit_cnt, miss_cnt, exp_hits, exp_misses);
        end
`endif
    endtask

    task automatic test_stats();
`ifdef DCACHE_STATS_EN
        do_reset();
        run_access(1'b0, 32'h80, 32'd0, 0, 1);
        run_access(1'b0, 32'h80, 32'd0, 0, 0);
        run_access(1'b1, 32'h84, 32'hCAFE_F00D, 0, 0);
        run_access(1'b0, 32'h84, 32'd0, 0, 0);
        #1;
        n_checks++;
        if (hit_cnt !== 32'd3 || miss_cnt !== 32'd1) begin
            n_fail++;
            $display("[TB] FAIL stats: hit=%0d miss=%0d, want 3 1", hit_cnt, miss_cnt);
        end
`endif
    endtask

    initial begin
        test_reset();
        test_clean_miss();
        test_store_load_hit();
        test_dirty_evict();
        test_delayed_ack();
        test_stray_ack();
        test_reset_during_rd();
        test_random();
        test_stats();
        @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/dcache_ctrl.md
# dcache_ctrl

Direct-mapped, write-back, write-allocate data cache placed between the pipeline's MEM stage and a slow line-wide data memory. It serves 32-bit loads and stores from the MEM stage with zero added latency on a hit. On a miss it stalls the pipeline while it writes back a dirty victim line and refills the line over a 256-bit request/acknowledge memory port.

## Interface
Parameters:
- INDEX_W, 4: index bits; the cache holds 2^INDEX_W lines of 256 bits (8 words).
- ADDR_W, 32: byte-address width. The tag is ADDR_W-INDEX_W-5 bits.

Ports:
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_i  in  1  reset, asynchronous and active-low.
- cpu_req_i  in  1  MEM stage is performing a load or store this cycle.
- cpu_we_i  in  1  1 = store, 0 = load.
- cpu_addr_i  in  ADDR_W  byte address; bits [1:0] are ignored.
- cpu_data_i  in  32  store data.
- cpu_data_o  out  32  load data, combinational; valid on a hit.
- cpu_stall_o  out  1  freezes PC, IF/ID, ID/EX and EX/MEM while high.
- mem_enable_o  out  1  memory request valid.
- mem_write_o  out  1  1 = line write, 0 = line read.
- mem_addr_o  out  ADDR_W  line address, with bits [4:0] = 0.
- mem_data_o  out  256  victim line for write-back.
- mem_data_i  in  256  refill line; valid only in the cycle mem_ack_i is high.
- mem_ack_i  in  1  one-cycle completion pulse from memory.
- hit_cnt_o, miss_cnt_o  out  32 each  present only with DCACHE_STATS_EN.

## Operation
- Address split: offset = addr[4:0], word select = addr[4:2], index = addr[INDEX_W+4:5], tag = the remaining upper bits.
- Per-line storage: valid bit, dirty bit, tag, 256-bit data. Word k occupies bits [32k+31:32k].
- Hit is defined as cpu_req_i && valid[idx] && tag match, evaluated only in IDLE.
- States and transitions:
  - IDLE:
    - On a load hit, cpu_data_o = selected word; stall = 0.
    - On a store hit, the selected word is written and dirty is set at the clock edge; stall = 0.
    - On a miss, stall = 1 combinationally. The next state is WB if the line is valid && dirty, otherwise RD.
  - WB:
    - mem_enable_o = 1, mem_write_o = 1.
    - mem_addr_o = {stored tag, idx, 5'b0}; mem_data_o = stored line.
    - On mem_ack_i, go to RD.
  - RD:
    - mem_enable_o = 1, mem_write_o = 0.
    - mem_addr_o = {req tag, idx, 5'b0}.
    - On mem_ack_i, install mem_data_i with valid = 1, dirty = 0 and the new tag, then go to FILL.
  - FILL: stall = 1 and the memory port is idle. Go to IDLE; the access is then re-evaluated and hits.
- cpu_stall_o = 1 in WB, RD and FILL, and in IDLE on a miss.
- A store miss allocates the line, then writes the word on the IDLE re-access, which sets dirty.
- cpu_data_o = 0 when there is no hit, including whenever cpu_req_i = 0.
- With cpu_req_i = 0, no state changes occur and stall = 0.

## Timing
- Reset (rst_i low, asynchronous) sets:
  - State to IDLE.
  - All valid and dirty bits to 0.
  - mem_enable_o = 0, mem_write_o = 0, mem_addr_o = 0, mem_data_o = 0.
  - Counters to 0.
  - cpu_stall_o = 0.
- Reset during WB or RD abandons the transaction immediately. mem_enable_o falls without waiting for ack. A partial refill is never installed.
- Hit latency: 0 cycles (same-cycle data, no stall).
- Clean miss stall = 1 + N_rd + 1 cycles, where N_rd is the number of RD cycles up to and including the ack cycle. Dirty miss adds N_wb.
- Memory handshake:
  - mem_enable_o is raised in the cycle after miss detection.
  - mem_enable_o and the address are held constant until the ack cycle.
  - mem_enable_o is deasserted, or switched to the read, in the following cycle.
  - mem_ack_i while mem_enable_o = 0 is ignored.
- The MEM stage holds cpu_req_i, cpu_we_i, cpu_addr_i and cpu_data_i stable while cpu_stall_o = 1. The block does not latch them.
- Tag array data, not a latched copy, drives mem_addr_o and mem_data_o in WB. The line is not overwritten before RD's ack, so this is safe.

## Configuration
- DCACHE_STATS_EN defined:
  - hit_cnt_o increments on each IDLE hit that is not the post-FILL re-access.
  - miss_cnt_o increments once per miss on its detection cycle.
  - Both counters wrap modulo 2^32.
- DCACHE_STATS_EN undefined: both ports and their counter logic are absent.

## Test plan
- After reset, load 0x0000_0040 → stall = 1 for 3 cycles with memory ack on the 1st RD cycle. mem_addr_o = 0x40, mem_write_o = 0. Then cpu_data_o = word 0 of the refill, stall = 0.
- Store 0xDEADBEEF to 0x44, then load 0x44 → both hit with no stall; the load returns 0xDEADBEEF.
- Load 0x244 (same index 2, different tag) after the previous step → WB issued at 0x40 whose mem_data_o[63:32] = 0xDEADBEEF, then RD at 0x240.
- Delay mem_ack_i by 5 cycles → mem_enable_o and mem_addr_o stay stable for all 5 cycles. A stray ack while enable = 0 changes nothing.
- Pull rst_i low during RD → mem_enable_o = 0 and stall = 0 asynchronously. A subsequent load to the same address misses again (valid = 0).
- With DCACHE_STATS_EN defined, run 1 miss followed by 3 hits to that line → hit_cnt_o = 3, miss_cnt_o = 1.
